// File: rtl/fir_feed_pkg.sv
// Shared types and defaults for the FIR input-side sample feeder.
package fir_feed_pkg;

   localparam int FEED_DATA_W    = 32;
   localparam int FEED_FLUSH_LEN = 103;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      STREAM = 2'd2,
      FLUSH  = 2'd3
   } feed_state_t;

   // One buffered upstream sample plus its end-of-frame marker.
   typedef struct packed {
      logic                   last;
      logic [FEED_DATA_W-1:0] data;
   } feed_entry_t;

endpackage

// File: rtl/fir_feed_fifo.sv
// Synchronous FIFO for the sample feeder. Stores whole entries, no bypass:
// a word written in cycle t is visible on rdata from cycle t+1 onward.
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
module fir_feed_fifo
   import fir_feed_pkg::*;
#(
   parameter type entry_t = feed_entry_t,
   parameter int  DEPTH   = 16
)(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  entry_t                   wdata,
   input  logic                     pop,
   output entry_t                   rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   entry_t      mem [DEPTH];
   logic        push_ok;
   logic        pop_ok;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign level   = wr_ptr - rd_ptr;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   // Pointer update; reset discards contents by collapsing both pointers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; the array itself needs no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/fir_sample_feeder.sv
// Input-side feeder for the 100-tap pipelined FIR. Buffers a framed
// valid/ready sample stream and drives one sample per clock into the
// filter's free-running x_in, then a zero tail of FLUSH_LEN samples.
// Build option FEED_HOLD_LAST_EN: on a streaming underrun x_out repeats
// the last real sample instead of driving zero.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for start; x_out held at zero, FIFO may pre-fill
//   PRIME  | waiting for a full FIFO or a complete frame in the FIFO
//   STREAM | one pop per cycle onto x_out; empty FIFO is an underrun
//   FLUSH  | FLUSH_LEN zero cycles to drain the filter; done on the last
module fir_sample_feeder
   import fir_feed_pkg::*;
#(
   parameter int DATA_W    = FEED_DATA_W,
   parameter int DEPTH     = 16,
   parameter int FLUSH_LEN = FEED_FLUSH_LEN,
   parameter int CNT_W     = 16
)(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [DATA_W-1:0]        s_data,
   input  logic                     s_valid,
   input  logic                     s_last,
   output logic                     s_ready,
   input  logic                     start,
   output logic [DATA_W-1:0]        x_out,
   output logic                     x_valid,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic [CNT_W-1:0]         underrun_cnt
);

   localparam int LW  = $clog2(DEPTH) + 1;
   localparam int FCW = $clog2(FLUSH_LEN + 1);

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } entry_t;

   feed_state_t    state;
   entry_t         wr_entry;
   entry_t         rd_entry;
   logic           fifo_full;
   logic           fifo_empty;
   logic           push;
   logic           pop;
   logic [LW-1:0]  pend_cnt;
   logic [FCW-1:0] flush_cnt;

   // s_ready depends on registered occupancy only, so a same-cycle pop
   // never opens room for a push into a full FIFO.
   assign s_ready  = !fifo_full;
   assign push     = s_valid && s_ready;
   assign pop      = (state == STREAM) && !fifo_empty;
   assign wr_entry = '{last: s_last, data: s_data};
   assign busy     = (state != IDLE);

   fir_feed_fifo #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   (wr_entry),
      .pop     (pop),
      .rdata   (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fill_level)
   );

   // Count of buffered entries that close a frame; lets PRIME release as
   // soon as a whole short frame is queued.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_cnt <= '0;
      end else begin
         if ((push && s_last) && !(pop && rd_entry.last))
            pend_cnt <= pend_cnt + 1'b1;
         else if (!(push && s_last) && (pop && rd_entry.last))
            pend_cnt <= pend_cnt - 1'b1;
      end
   end

   // Sequencer with registered filter-side outputs, flush timer and
   // saturating underrun counter. done is raised so that it coincides
   // with the final FLUSH cycle (flush_cnt == 1).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         x_out        <= '0;
         x_valid      <= 1'b0;
         done         <= 1'b0;
         flush_cnt    <= '0;
         underrun_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               x_out   <= '0;
               x_valid <= 1'b0;
               if (start) state <= PRIME;
            end
            PRIME: begin
               x_out   <= '0;
               x_valid <= 1'b0;
               if (fifo_full || (pend_cnt != '0)) state <= STREAM;
            end
            STREAM: begin
               if (!fifo_empty) begin
                  x_out   <= rd_entry.data;
                  x_valid <= 1'b1;
                  if (rd_entry.last) begin
                     flush_cnt <= FCW'(FLUSH_LEN);
                     done      <= (FLUSH_LEN == 1);
                     state     <= FLUSH;
                  end
               end else begin
`ifdef FEED_HOLD_LAST_EN
                  x_out   <= x_out;
`else
                  x_out   <= '0;
`endif
                  x_valid <= 1'b0;
                  if (underrun_cnt != {CNT_W{1'b1}})
                     underrun_cnt <= underrun_cnt + 1'b1;
               end
            end
            FLUSH: begin
               x_out     <= '0;
               x_valid   <= 1'b0;
               flush_cnt <= flush_cnt - 1'b1;
               done      <= (flush_cnt == FCW'(2));
               if (flush_cnt == FCW'(1)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
